// File: rtl/fft_pkg.sv
// Shared types, default sizes and the bit-reversal helper for the FFT output reorder buffer.
package fft_pkg;

    localparam int DEF_WIDTH  = 14;
    localparam int DEF_N_LOG2 = 10;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } wr_state_t;

    // Reverse the low nbits of val (nbits <= 16); upper result bits are zero.
    function automatic logic [15:0] bitrev(input logic [15:0] val, input int unsigned nbits);
        logic [15:0] rev;
        rev = 16'd0;
        for (int i = 0; i < 16; i++) begin
            rev[i[3:0]] = val[4'd15 - i[3:0]];
        end
        return rev >> (32'd16 - nbits);
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One reorder bank: simple dual-port RAM, synchronous write, registered read that
// holds its output whenever no read is requested.
module fft_reorder_bank
    import fft_pkg::*;
#(
    parameter int DW = 2 * DEF_WIDTH,
    parameter int AW = DEF_N_LOG2
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    // Read port: capture the addressed word on a read strobe, otherwise hold it
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Storage array write and read-data register
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT output frames into natural bin order using two
// ping-pong banks. Writer never stalls; reader honours do_ready.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int N_LOG2 = DEF_N_LOG2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              di_en,
    input  logic [WIDTH-1:0]  di_re,
    input  logic [WIDTH-1:0]  di_im,
    input  logic [N_LOG2-1:0] di_num,
    output logic              do_en,
    output logic [WIDTH-1:0]  do_re,
    output logic [WIDTH-1:0]  do_im,
    output logic [N_LOG2-1:0] do_num,
    input  logic              do_ready,
    output logic              ovf
);

    localparam int                DW       = 2 * WIDTH;
    localparam logic [N_LOG2-1:0] LAST_IDX = {N_LOG2{1'b1}};
    localparam logic [N_LOG2-1:0] ZERO_IDX = {N_LOG2{1'b0}};
    localparam logic [N_LOG2-1:0] ONE_IDX  = N_LOG2'(1'b1);

    wr_state_t         wr_state_q, wr_state_d;
    bank_state_t       bank_q [2];
    bank_state_t       bank_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic              rd_active_q, rd_active_d;
    logic [N_LOG2-1:0] rd_addr_q, rd_addr_d;
    logic              s1_valid_q, s1_valid_d;
    logic              s1_bank_q, s1_bank_d;
    logic [N_LOG2-1:0] s1_num_q, s1_num_d;
    logic              do_en_q, do_en_d;
    logic [WIDTH-1:0]  do_re_q, do_re_d;
    logic [WIDTH-1:0]  do_im_q, do_im_d;
    logic [N_LOG2-1:0] do_num_q, do_num_d;

    logic              frame_start_s, tgt_free_s;
    logic              wr_en_s, wr_fill_s, wr_full_s;
    logic [N_LOG2-1:0] wr_addr_s;
    logic              out_adv_s, s1_load_s, rd_start_s, issue_s, last_issue_s;
    logic [DW-1:0]     rdata0_s, rdata1_s, rd_word_s;

    // Read-side handshake and issue decisions (two-stage pipeline: RAM register, output register)
    always_comb begin
        out_adv_s    = !do_en_q || do_ready;
        s1_load_s    = !s1_valid_q || out_adv_s;
        rd_start_s   = !rd_active_q && (bank_q[rd_ptr_q] == FULL);
        issue_s      = (rd_active_q || rd_start_s) && s1_load_s;
        last_issue_s = issue_s && (rd_addr_q == LAST_IDX);
    end

    // Writer FSM: frame acceptance, drop on overflow, restart on a new frame start.
    // A bank whose last word is being read out this cycle already counts as free,
    // since its data then lives in the read pipeline, not the RAM.
    always_comb begin
        wr_state_d    = wr_state_q;
        wr_ptr_d      = wr_ptr_q;
        ovf_d         = ovf_q;
        wr_en_s       = 1'b0;
        wr_fill_s     = 1'b0;
        wr_full_s     = 1'b0;
        wr_addr_s     = N_LOG2'(bitrev(16'(di_num), N_LOG2));
        frame_start_s = di_en && (di_num == ZERO_IDX);
        tgt_free_s    = (bank_q[wr_ptr_q] == EMPTY)
                     || (last_issue_s && (rd_ptr_q == wr_ptr_q))
                     || (wr_state_q == WRITE);
        if (frame_start_s) begin
            if (tgt_free_s) begin
                wr_state_d = WRITE;
                wr_en_s    = 1'b1;
                wr_fill_s  = 1'b1;
            end else begin
                wr_state_d = DROP;
                ovf_d      = 1'b1;
            end
        end else begin
            case (wr_state_q)
                WRITE: begin
                    if (di_en) begin
                        wr_en_s = 1'b1;
                        if (di_num == LAST_IDX) begin
                            wr_full_s  = 1'b1;
                            wr_ptr_d   = ~wr_ptr_q;
                            wr_state_d = IDLE;
                        end else begin
                            wr_state_d = WRITE;
                        end
                    end else begin
                        wr_state_d = WRITE;
                    end
                end
                DROP: begin
                    if (di_en && (di_num == LAST_IDX)) begin
                        wr_state_d = IDLE;
                    end else begin
                        wr_state_d = DROP;
                    end
                end
                IDLE:    wr_state_d = IDLE;
                default: wr_state_d = IDLE;
            endcase
        end
    end

    // Bank lifecycle: later assignments win, so a refill overrides a same-cycle release
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        if (rd_start_s) begin
            bank_d[rd_ptr_q] = DRAINING;
        end else begin
            bank_d[rd_ptr_q] = bank_q[rd_ptr_q];
        end
        if (last_issue_s) begin
            bank_d[rd_ptr_q] = EMPTY;
        end else begin
            bank_d[rd_ptr_q] = bank_d[rd_ptr_q];
        end
        if (wr_fill_s) begin
            bank_d[wr_ptr_q] = FILLING;
        end else if (wr_full_s) begin
            bank_d[wr_ptr_q] = FULL;
        end else begin
            bank_d[wr_ptr_q] = bank_d[wr_ptr_q];
        end
    end

    // Reader address counter and bank pointer
    always_comb begin
        rd_active_d = rd_active_q;
        rd_addr_d   = rd_addr_q;
        rd_ptr_d    = rd_ptr_q;
        if (issue_s) begin
            if (rd_addr_q == LAST_IDX) begin
                rd_active_d = 1'b0;
                rd_addr_d   = ZERO_IDX;
                rd_ptr_d    = ~rd_ptr_q;
            end else begin
                rd_active_d = 1'b1;
                rd_addr_d   = rd_addr_q + ONE_IDX;
            end
        end else if (rd_start_s) begin
            rd_active_d = 1'b1;
        end else begin
            rd_active_d = rd_active_q;
        end
    end

    // Pipeline stage tracking the RAM read register, then the held output register
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_num_d   = s1_num_q;
        s1_bank_d  = s1_bank_q;
        do_en_d    = do_en_q;
        do_re_d    = do_re_q;
        do_im_d    = do_im_q;
        do_num_d   = do_num_q;
        rd_word_s  = s1_bank_q ? rdata1_s : rdata0_s;
        if (s1_load_s) begin
            s1_valid_d = issue_s;
            s1_num_d   = rd_addr_q;
            s1_bank_d  = rd_ptr_q;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (out_adv_s) begin
            do_en_d = s1_valid_q;
            if (s1_valid_q) begin
                do_re_d  = rd_word_s[DW-1:WIDTH];
                do_im_d  = rd_word_s[WIDTH-1:0];
                do_num_d = s1_num_q;
            end else begin
                do_num_d = do_num_q;
            end
        end else begin
            do_en_d = do_en_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state_q  <= IDLE;
            bank_q[0]   <= EMPTY;
            bank_q[1]   <= EMPTY;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            ovf_q       <= 1'b0;
            rd_active_q <= 1'b0;
            rd_addr_q   <= ZERO_IDX;
            s1_valid_q  <= 1'b0;
            s1_num_q    <= ZERO_IDX;
            s1_bank_q   <= 1'b0;
            do_en_q     <= 1'b0;
            do_re_q     <= {WIDTH{1'b0}};
            do_im_q     <= {WIDTH{1'b0}};
            do_num_q    <= ZERO_IDX;
        end else begin
            wr_state_q  <= wr_state_d;
            bank_q[0]   <= bank_d[0];
            bank_q[1]   <= bank_d[1];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ovf_q       <= ovf_d;
            rd_active_q <= rd_active_d;
            rd_addr_q   <= rd_addr_d;
            s1_valid_q  <= s1_valid_d;
            s1_num_q    <= s1_num_d;
            s1_bank_q   <= s1_bank_d;
            do_en_q     <= do_en_d;
            do_re_q     <= do_re_d;
            do_im_q     <= do_im_d;
            do_num_q    <= do_num_d;
        end
    end

    fft_reorder_bank #(.DW(DW), .AW(N_LOG2)) u_bank0 (
        .clock (clock),
        .we    (wr_en_s && !wr_ptr_q),
        .waddr (wr_addr_s),
        .wdata ({di_re, di_im}),
        .re    (issue_s && !rd_ptr_q),
        .raddr (rd_addr_q),
        .rdata (rdata0_s)
    );

    fft_reorder_bank #(.DW(DW), .AW(N_LOG2)) u_bank1 (
        .clock (clock),
        .we    (wr_en_s && wr_ptr_q),
        .waddr (wr_addr_s),
        .wdata ({di_re, di_im}),
        .re    (issue_s && rd_ptr_q),
        .raddr (rd_addr_q),
        .rdata (rdata1_s)
    );

    assign do_en  = do_en_q;
    assign do_re  = do_re_q;
    assign do_im  = do_im_q;
    assign do_num = do_num_q;
    assign ovf    = ovf_q;

endmodule
